// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer between ID and EX.
// Optional per-mode transfer statistics are enabled by defining IMM_GEN_STATS_EN.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [25:0]       imm26,
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic [2:0]        ImmSrc,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   imm_out,
  output logic [TAG_W-1:0]  out_tag,
  output logic [2:0]        out_mode
`ifdef IMM_GEN_STATS_EN
  ,
  output logic [5*16-1:0]   stat_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam logic [2:0] MODE_SEXT   = 3'd0;
  localparam logic [2:0] MODE_ZEXT   = 3'd1;
  localparam logic [2:0] MODE_LUI    = 3'd2;
  localparam logic [2:0] MODE_BRANCH = 3'd3;
  localparam logic [2:0] MODE_JUMP   = 3'd4;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0]  main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
  logic [2:0]        main_mode_q, main_mode_d, skid_mode_q, skid_mode_d;

  logic [15:0]       imm16;
  logic [XLEN-1:0]   sext_val;
  logic [XLEN-1:0]   new_imm;
  logic [2:0]        new_mode;
  logic              in_xfer;
  logic              out_xfer;
  logic              unused_pc_low;

  assign unused_pc_low = ^pc_plus4[27:0];

  always_comb begin
    imm16    = imm26[15:0];
    sext_val = {{(XLEN-16){imm16[15]}}, imm16};
    new_mode = (ImmSrc > MODE_JUMP) ? MODE_SEXT : ImmSrc;
    new_imm  = sext_val;
    case (new_mode)
      MODE_ZEXT:   new_imm = {{(XLEN-16){1'b0}}, imm16};
      // Shifting the sign-extended value keeps the sign above bit 31 for wide XLEN.
      MODE_LUI:    new_imm = sext_val << 16;
      MODE_BRANCH: new_imm = sext_val << 2;
      MODE_JUMP:   new_imm = {pc_plus4[XLEN-1:28], imm26, 2'b00};
      default:     new_imm = sext_val;
    endcase
  end

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = in_valid && in_ready && !flush;
  assign out_xfer  = out_valid && out_ready;

  assign imm_out  = main_imm_q;
  assign out_tag  = main_tag_q;
  assign out_mode = main_mode_q;

  always_comb begin
    state_d     = state_q;
    main_imm_d  = main_imm_q;
    main_tag_d  = main_tag_q;
    main_mode_d = main_mode_q;
    skid_imm_d  = skid_imm_q;
    skid_tag_d  = skid_tag_q;
    skid_mode_d = skid_mode_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_imm_d  = new_imm;
          main_tag_d  = in_tag;
          main_mode_d = new_mode;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_imm_d  = new_imm;
          main_tag_d  = in_tag;
          main_mode_d = new_mode;
        end else if (in_xfer) begin
          skid_imm_d  = new_imm;
          skid_tag_d  = in_tag;
          skid_mode_d = new_mode;
          state_d     = TWO;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // A flush must leave imm_out untouched, so the skid is not promoted.
        if (out_xfer && !flush) begin
          main_imm_d  = skid_imm_q;
          main_tag_d  = skid_tag_q;
          main_mode_d = skid_mode_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_imm_q  <= '0;
      main_tag_q  <= '0;
      main_mode_q <= '0;
      skid_imm_q  <= '0;
      skid_tag_q  <= '0;
      skid_mode_q <= '0;
    end else begin
      state_q     <= state_d;
      main_imm_q  <= main_imm_d;
      main_tag_q  <= main_tag_d;
      main_mode_q <= main_mode_d;
      skid_imm_q  <= skid_imm_d;
      skid_tag_q  <= skid_tag_d;
      skid_mode_q <= skid_mode_d;
    end
  end

`ifdef IMM_GEN_STATS_EN
  logic [4:0][15:0] cnt_q, cnt_d;

  // Output transfers are counted even during flush since downstream consumed them.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (out_xfer && (main_mode_q == 3'(i)) && (cnt_q[i] != 16'hFFFF)) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stat_count = cnt_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard testbench for imm_gen_pipe: directed vectors push expected entries,
// a negedge monitor pops and compares on every output transfer.
module tb_imm_gen_pipe;

  localparam int XLEN  = 32;
  localparam int TAG_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [25:0]       imm26 = '0;
  logic [XLEN-1:0]   pc_plus4 = '0;
  logic [2:0]        imm_src = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [XLEN-1:0]   imm_out;
  logic [TAG_W-1:0]  out_tag;
  logic [2:0]        out_mode;
`ifdef IMM_GEN_STATS_EN
  logic [5*16-1:0]   stat_count;
`endif

  typedef struct packed {
    logic [31:0] imm;
    logic [7:0]  tag;
    logic [2:0]  mode;
  } entry_t;

  entry_t exp_q[$];
  entry_t mon_e;
  int checks = 0;
  int failures = 0;
  int out_count = 0;

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm26     (imm26),
    .pc_plus4  (pc_plus4),
    .ImmSrc    (imm_src),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm_out   (imm_out),
    .out_tag   (out_tag),
    .out_mode  (out_mode)
`ifdef IMM_GEN_STATS_EN
    ,
    .stat_count(stat_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until accepted, then records the hand-computed result.
  task automatic apply_stimulus(input logic [2:0] mode, input logic [25:0] imm, input logic [31:0] pc,
                                input logic [7:0] tag, input logic [31:0] exp_imm, input logic [2:0] exp_mode);
    bit accepted = 0;
    imm_src  = mode;
    imm26    = imm;
    pc_plus4 = pc;
    in_tag   = tag;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1;
        break;
      end
    end
    if (!accepted) begin
      check_output("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back('{imm: exp_imm, tag: tag, mode: exp_mode});
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    check_output("drain_left", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output actual=%h expected=none", imm_out);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("out_imm", imm_out, mon_e.imm);
        check_output("out_tag", 32'(out_tag), 32'(mon_e.tag));
        check_output("out_mode", 32'(out_mode), 32'(mon_e.mode));
        out_count++;
      end
    end
  end

  initial begin
    int base;
    longint t0;

    // Reset state
    #12;
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    check_output("rst_imm_out", imm_out, 32'd0);
    check_output("rst_out_tag", 32'(out_tag), 32'd0);
    check_output("rst_out_mode", 32'(out_mode), 32'd0);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;

    // Basic SEXT with one-cycle latency
    apply_stimulus(3'b000, 26'h0008004, 32'h0, 8'h11, 32'hFFFF8004, 3'd0);
    check_output("latency_out_valid", 32'(out_valid), 32'd1);
    wait_drain();

    // Mode sweep
    apply_stimulus(3'b001, 26'h0001234, 32'h0, 8'h21, 32'h00001234, 3'd1);
    apply_stimulus(3'b010, 26'h0001234, 32'h0, 8'h22, 32'h12340000, 3'd2);
    apply_stimulus(3'b011, 26'h000FFFF, 32'h0, 8'h23, 32'hFFFFFFFC, 3'd3);
    apply_stimulus(3'b100, 26'h0000100, 32'hA0000008, 8'h24, 32'hA0000400, 3'd4);
    apply_stimulus(3'b111, 26'h0001234, 32'h0, 8'h25, 32'h00001234, 3'd0);
    apply_stimulus(3'b101, 26'h000F234, 32'h0, 8'h26, 32'hFFFFF234, 3'd0);
    apply_stimulus(3'b010, 26'h0008001, 32'h0, 8'h27, 32'h80010000, 3'd2);
    wait_drain();

    // Backpressure: skid fills, third request waits
    base = out_count;
    out_ready = 1'b0;
    apply_stimulus(3'b000, 26'h0000001, 32'h0, 8'h31, 32'h00000001, 3'd0);
    check_output("bp_in_ready_one", 32'(in_ready), 32'd1);
    apply_stimulus(3'b001, 26'h000FFFF, 32'h0, 8'h32, 32'h0000FFFF, 3'd1);
    check_output("bp_in_ready_two", 32'(in_ready), 32'd0);
    fork
      apply_stimulus(3'b010, 26'h0000001, 32'h0, 8'h33, 32'h00010000, 3'd2);
    join_none
    repeat (3) tick();
    check_output("bp_in_ready_held", 32'(in_ready), 32'd0);
    check_output("bp_hold_imm", imm_out, 32'h00000001);
    check_output("bp_hold_tag", 32'(out_tag), 32'h31);
    out_ready = 1'b1;
    wait fork;
    wait_drain();
    check_output("bp_out_count", 32'(out_count - base), 32'd3);

    // Full throughput with simultaneous in/out transfers
    base = out_count;
    t0 = $time;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(3'b001, 26'(16'h0100 + i), 32'h0, 8'(8'h40 + i), 32'h00000100 + 32'(i), 3'd1);
      check_output("tp_in_ready", 32'(in_ready), 32'd1);
    end
    check_output("tp_elapsed", 32'($time - t0), 32'd200);
    wait_drain();
    check_output("tp_out_count", 32'(out_count - base), 32'd20);

    // Flush in TWO with a pending input
    out_ready = 1'b0;
    apply_stimulus(3'b000, 26'h0000055, 32'h0, 8'h51, 32'h00000055, 3'd0);
    apply_stimulus(3'b011, 26'h0000001, 32'h0, 8'h52, 32'h00000004, 3'd3);
    imm_src  = 3'b001;
    imm26    = 26'h0000077;
    in_tag   = 8'h53;
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check_output("flush_out_valid", 32'(out_valid), 32'd0);
    check_output("flush_in_ready", 32'(in_ready), 32'd1);
    check_output("flush_imm_kept", imm_out, 32'h00000055);
    out_ready = 1'b1;
    repeat (3) tick();
    apply_stimulus(3'b100, 26'h3FFFFFF, 32'h50000000, 8'h54, 32'h5FFFFFFC, 3'd4);
    wait_drain();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    apply_stimulus(3'b000, 26'h0000123, 32'h0, 8'h61, 32'h00000123, 3'd0);
    apply_stimulus(3'b001, 26'h0000456, 32'h0, 8'h62, 32'h00000456, 3'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("arst_out_valid", 32'(out_valid), 32'd0);
    check_output("arst_in_ready", 32'(in_ready), 32'd1);
    check_output("arst_imm_out", imm_out, 32'd0);
    check_output("arst_out_tag", 32'(out_tag), 32'd0);
    exp_q.delete();
    #2;
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    apply_stimulus(3'b000, 26'h0007FFF, 32'h0, 8'h63, 32'h00007FFF, 3'd0);
    wait_drain();

`ifdef IMM_GEN_STATS_EN
    check_output("stat_sext_one", 32'(stat_count[15:0]), 32'd1);
    for (int i = 0; i < 70000; i++) begin
      apply_stimulus(3'b000, 26'h0000002, 32'h0, 8'h70, 32'h00000002, 3'd0);
    end
    wait_drain();
    check_output("stat_sext_sat", 32'(stat_count[15:0]), 32'h0000FFFF);
    check_output("stat_zext_zero", 32'(stat_count[31:16]), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
